// File: rtl/trigger_detect_pkg.sv
// Shared types, widths and the magnitude helper for the trigger detector.
package trigger_detect_pkg;

   localparam int unsigned BIN_W  = 6;
   localparam int unsigned MAG_W  = 9;
   localparam int unsigned DATA_W = 10;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned HOLD_W = 20;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      WRITING,
      SCAN,
      DRAIN,
      DECIDE,
      HOLDOFF
   } state_t;

   // |d| as 9-bit unsigned; the single unrepresentable value -512 saturates to 511.
   function automatic logic [MAG_W-1:0] abs_sat(input logic [DATA_W-1:0] d);
      if (!d[DATA_W-1])
         abs_sat = d[MAG_W-1:0];
      else if (d == {1'b1, {(DATA_W-1){1'b0}}})
         abs_sat = '1;
      else
         abs_sat = (~d[MAG_W-1:0]) + MAG_W'(1);
   endfunction

endpackage

// File: rtl/bin_peak_tracker.sv
// Running peak-magnitude tracker over a stream of (bin, data) samples.
module bin_peak_tracker
   import trigger_detect_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              valid,
   input  logic [BIN_W-1:0]  bin,
   input  logic [DATA_W-1:0] data,
   output logic [MAG_W-1:0]  max_mag,
   output logic [BIN_W-1:0]  max_bin
);

   logic [MAG_W-1:0] mag_c;

   assign mag_c = abs_sat(data);

   // Strict greater-than keeps the earliest (lowest) bin on ties.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         max_mag <= '0;
         max_bin <= '0;
      end else if (clear) begin
         max_mag <= '0;
         max_bin <= '0;
      end else if (valid && (mag_c > max_mag)) begin
         max_mag <= mag_c;
         max_bin <= bin;
      end
   end

endmodule

// File: rtl/trigger_detector.sv
// Scans a bin band of the FFT output RAM after each frame and raises a trigger
// after enough consecutive frames exceed the threshold; gates the FFT meanwhile.
module trigger_detector
   import trigger_detect_pkg::*;
#(
   parameter int unsigned BIN_LO         = 4,
   parameter int unsigned BIN_HI         = 20,
   parameter int unsigned THRESHOLD      = 200,
   parameter int unsigned CONSEC_FRAMES  = 2,
   parameter int unsigned HOLDOFF_CYCLES = 1000,
   parameter int unsigned RAM_RD_LATENCY = 1
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              detector_enable,
   input  logic              fft_output_RAM_ready,
   input  logic [DATA_W-1:0] fft_output_RAM_data,
   output logic [BIN_W-1:0]  fft_output_RAM_addr,
   output logic              trigger_fft_enable,
   output logic              trigger,
   output logic [BIN_W-1:0]  peak_bin,
   output logic [MAG_W-1:0]  peak_mag,
   output logic [CNT_W-1:0]  consec_count
);

   state_t             state, state_next;
   logic [BIN_W-1:0]   addr_next;
   logic               en_next;
   logic               trig_next;
   logic [BIN_W-1:0]   pbin_next;
   logic [MAG_W-1:0]   pmag_next;
   logic [CNT_W-1:0]   consec_next;
   logic [CNT_W-1:0]   consec_inc_c;
   logic [HOLD_W-1:0]  wait_cnt, wait_next;
   logic               clear_c;
   logic               pipe_keep_c;

   logic [RAM_RD_LATENCY-1:0] pipe_vld;
   logic [BIN_W-1:0]          pipe_bin [RAM_RD_LATENCY];

   logic [MAG_W-1:0]   max_mag;
   logic [BIN_W-1:0]   max_bin;

   assign consec_inc_c = (consec_count == '1) ? consec_count : consec_count + CNT_W'(1);

   // Next-state and next-output decode; detector_enable low overrides everything.
   always_comb begin
      state_next  = state;
      addr_next   = fft_output_RAM_addr;
      trig_next   = 1'b0;
      pbin_next   = peak_bin;
      pmag_next   = peak_mag;
      consec_next = consec_count;
      wait_next   = wait_cnt;

      case (state)
         IDLE: begin
            if (detector_enable)
               state_next = ARMED;
         end
         ARMED: begin
            if (!fft_output_RAM_ready)
               state_next = WRITING;
         end
         WRITING: begin
            if (fft_output_RAM_ready) begin
               state_next = SCAN;
               addr_next  = BIN_W'(BIN_LO);
            end
         end
         SCAN: begin
            if (!fft_output_RAM_ready) begin
               state_next  = WRITING;
               consec_next = '0;
            end else if (fft_output_RAM_addr == BIN_W'(BIN_HI)) begin
               state_next = DRAIN;
               wait_next  = '0;
            end else begin
               addr_next = fft_output_RAM_addr + BIN_W'(1);
            end
         end
         DRAIN: begin
            if (!fft_output_RAM_ready) begin
               state_next  = WRITING;
               consec_next = '0;
               wait_next   = '0;
            end else if (wait_cnt == HOLD_W'(RAM_RD_LATENCY - 1)) begin
               state_next = DECIDE;
               wait_next  = '0;
            end else begin
               wait_next = wait_cnt + HOLD_W'(1);
            end
         end
         DECIDE: begin
            if (max_mag >= MAG_W'(THRESHOLD)) begin
               if (consec_inc_c >= CNT_W'(CONSEC_FRAMES)) begin
                  trig_next   = 1'b1;
                  pbin_next   = max_bin;
                  pmag_next   = max_mag;
                  consec_next = '0;
                  wait_next   = '0;
                  state_next  = HOLDOFF;
               end else begin
                  consec_next = consec_inc_c;
                  state_next  = ARMED;
               end
            end else begin
               consec_next = '0;
               state_next  = ARMED;
            end
         end
         HOLDOFF: begin
            if (wait_cnt == HOLD_W'(HOLDOFF_CYCLES - 1)) begin
               state_next = ARMED;
               wait_next  = '0;
            end else begin
               wait_next = wait_cnt + HOLD_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (!detector_enable) begin
         state_next  = IDLE;
         consec_next = '0;
         trig_next   = 1'b0;
         pbin_next   = peak_bin;
         pmag_next   = peak_mag;
         wait_next   = '0;
      end
   end

   assign en_next     = (state_next == ARMED);
   assign clear_c     = (state == WRITING) && (state_next == SCAN);
   assign pipe_keep_c = (state_next == SCAN) || (state_next == DRAIN);

   // State and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state               <= IDLE;
         fft_output_RAM_addr <= '0;
         trigger_fft_enable  <= 1'b0;
         trigger             <= 1'b0;
         peak_bin            <= '0;
         peak_mag            <= '0;
         consec_count        <= '0;
         wait_cnt            <= '0;
      end else begin
         state               <= state_next;
         fft_output_RAM_addr <= addr_next;
         trigger_fft_enable  <= en_next;
         trigger             <= trig_next;
         peak_bin            <= pbin_next;
         peak_mag            <= pmag_next;
         consec_count        <= consec_next;
         wait_cnt            <= wait_next;
      end
   end

   // Valid flags aligned with RAM read latency; flushed on abort so stale reads never land.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pipe_vld <= '0;
      else if (!pipe_keep_c)
         pipe_vld <= '0;
      else
         pipe_vld <= RAM_RD_LATENCY'({pipe_vld, (state == SCAN)});
   end

   // Bin numbers travelling alongside the valid flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RAM_RD_LATENCY; i++)
            pipe_bin[i] <= '0;
      end else begin
         pipe_bin[0] <= fft_output_RAM_addr;
         for (int i = 1; i < RAM_RD_LATENCY; i++)
            pipe_bin[i] <= pipe_bin[i-1];
      end
   end

   bin_peak_tracker u_tracker (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear_c),
      .valid   (pipe_vld[RAM_RD_LATENCY-1]),
      .bin     (pipe_bin[RAM_RD_LATENCY-1]),
      .data    (fft_output_RAM_data),
      .max_mag (max_mag),
      .max_bin (max_bin)
   );

endmodule

// File: tb/tb_trigger_detector.sv
// Directed bench: two detector instances (defaults, and CONSEC_FRAMES=1 with
// 2-cycle RAM latency) fed by behavioural RAMs; triggers checked via scoreboards.
module tb_trigger_detector;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_a, det_en_a, ready_a, en_a, trig_a;
   logic [9:0] data_a;
   logic [5:0] addr_a, pbin_a;
   logic [8:0] pmag_a;
   logic [3:0] cc_a;

   logic       reset_b, det_en_b, ready_b, en_b, trig_b;
   logic [9:0] data_b;
   logic [5:0] addr_b, pbin_b;
   logic [8:0] pmag_b;
   logic [3:0] cc_b;

   logic [9:0] ram_a [64];
   logic [9:0] ram_b [64];
   logic [9:0] rd_b1;

   trigger_detector u_dut_a (
      .clk                  (clk),
      .reset                (reset_a),
      .detector_enable      (det_en_a),
      .fft_output_RAM_ready (ready_a),
      .fft_output_RAM_data  (data_a),
      .fft_output_RAM_addr  (addr_a),
      .trigger_fft_enable   (en_a),
      .trigger              (trig_a),
      .peak_bin             (pbin_a),
      .peak_mag             (pmag_a),
      .consec_count         (cc_a)
   );

   trigger_detector #(
      .CONSEC_FRAMES  (1),
      .HOLDOFF_CYCLES (16),
      .RAM_RD_LATENCY (2)
   ) u_dut_b (
      .clk                  (clk),
      .reset                (reset_b),
      .detector_enable      (det_en_b),
      .fft_output_RAM_ready (ready_b),
      .fft_output_RAM_data  (data_b),
      .fft_output_RAM_addr  (addr_b),
      .trigger_fft_enable   (en_b),
      .trigger              (trig_b),
      .peak_bin             (pbin_b),
      .peak_mag             (pmag_b),
      .consec_count         (cc_b)
   );

   // Behavioural RAM read ports: A has 1-cycle latency, B has 2.
   always_ff @(posedge clk) begin
      data_a <= ram_a[addr_a];
      rd_b1  <= ram_b[addr_b];
      data_b <= rd_b1;
   end

   typedef struct {
      int cyc;
      int bin;
      int mag;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input bit sel, input int c, input int b, input int m);
      exp_t e;
      e.cyc = c;
      e.bin = b;
      e.mag = m;
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
   endtask

   // Compare any trigger pulse against the next expected one; flag overdue expectations.
   task automatic sb_a();
      exp_t e;
      if (q_a.size() > 0 && q_a[0].cyc < cyc) begin
         e = q_a.pop_front();
         check("a missed trigger", 32'(cyc), 32'(e.cyc));
      end
      if (trig_a === 1'b1) begin
         if (q_a.size() == 0) begin
            check("a unexpected trigger", 32'(trig_a), 32'(0));
         end else begin
            e = q_a.pop_front();
            check("a trigger cycle", 32'(cyc), 32'(e.cyc));
            check("a peak_bin", 32'(pbin_a), 32'(e.bin));
            check("a peak_mag", 32'(pmag_a), 32'(e.mag));
         end
      end
   endtask

   task automatic sb_b();
      exp_t e;
      if (q_b.size() > 0 && q_b[0].cyc < cyc) begin
         e = q_b.pop_front();
         check("b missed trigger", 32'(cyc), 32'(e.cyc));
      end
      if (trig_b === 1'b1) begin
         if (q_b.size() == 0) begin
            check("b unexpected trigger", 32'(trig_b), 32'(0));
         end else begin
            e = q_b.pop_front();
            check("b trigger cycle", 32'(cyc), 32'(e.cyc));
            check("b peak_bin", 32'(pbin_b), 32'(e.bin));
            check("b peak_mag", 32'(pmag_b), 32'(e.mag));
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      sb_a();
      sb_b();
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic fill(input bit sel, input logic [9:0] v);
      for (int i = 0; i < 64; i++) begin
         if (sel) ram_b[i] = v;
         else     ram_a[i] = v;
      end
   endtask

   task automatic set_ready(input bit sel, input logic v);
      if (sel) ready_b = v;
      else     ready_a = v;
   endtask

   function automatic logic get_en(input bit sel);
      return sel ? en_b : en_a;
   endfunction

   task automatic wait_en(input bit sel);
      int n = 0;
      while (get_en(sel) !== 1'b1 && n < 3000) begin
         tick();
         n++;
      end
      if (n >= 3000)
         check("wait fft enable timeout", 32'(get_en(sel)), 32'(1));
   endtask

   // Emulate an FFT frame write: ready low two cycles, then high; returns the rise cycle.
   task automatic arm_and_rise(input bit sel, output int rise);
      wait_en(sel);
      set_ready(sel, 1'b0);
      tick();
      tick();
      set_ready(sel, 1'b1);
      rise = cyc;
   endtask

   initial begin
      int r;
      int t_trig;
      int en_hi;

      reset_a  = 1'b1;
      reset_b  = 1'b1;
      det_en_a = 1'b0;
      det_en_b = 1'b0;
      ready_a  = 1'b1;
      ready_b  = 1'b1;
      fill(0, 10'd5);
      fill(1, 10'd5);
      tick();
      tick();

      // Reset values
      check("rst a addr", 32'(addr_a), 32'(0));
      check("rst a enable", 32'(en_a), 32'(0));
      check("rst a trigger", 32'(trig_a), 32'(0));
      check("rst a peak_bin", 32'(pbin_a), 32'(0));
      check("rst a peak_mag", 32'(pmag_a), 32'(0));
      check("rst a consec", 32'(cc_a), 32'(0));
      check("rst b enable", 32'(en_b), 32'(0));

      det_en_a = 1'b1;
      reset_a  = 1'b0;
      reset_b  = 1'b0;
      tick();
      check("a armed after release", 32'(en_a), 32'(1));
      check("b idle while disabled", 32'(en_b), 32'(0));

      // Two qualifying frames on A (bin 10 = -300) -> one trigger 20 cycles after second rise
      ram_a[10] = 10'(-300);
      arm_and_rise(0, r);
      run(22);
      check("a consec after frame 1", 32'(cc_a), 32'(1));
      arm_and_rise(0, r);
      t_trig = r + 20;
      push(0, t_trig, 10, 300);
      run(20);
      check("a consec after trigger", 32'(cc_a), 32'(0));
      check("a held peak_bin", 32'(pbin_a), 32'(10));
      check("a held peak_mag", 32'(pmag_a), 32'(300));
      en_hi = (en_a !== 1'b0) ? 1 : 0;
      while (cyc < t_trig + 999) begin
         tick();
         if (en_a !== 1'b0) en_hi++;
      end
      check("a holdoff enable low cycles", 32'(en_hi), 32'(0));
      tick();
      check("a holdoff release", 32'(en_a), 32'(1));

      // Qualifying frame then weak frame -> count 1 then 0, no trigger
      fill(0, 10'd5);
      ram_a[10] = 10'd300;
      arm_and_rise(0, r);
      run(22);
      check("a consec single", 32'(cc_a), 32'(1));
      fill(0, 10'd100);
      arm_and_rise(0, r);
      run(22);
      check("a consec cleared by weak frame", 32'(cc_a), 32'(0));

      // B: tie -> lower bin, out-of-band bin ignored
      det_en_b = 1'b1;
      fill(1, 10'd5);
      ram_b[3]  = 10'd511;
      ram_b[7]  = 10'd250;
      ram_b[15] = 10'd250;
      arm_and_rise(1, r);
      push(1, r + 21, 7, 250);
      run(21);
      check("b consec after trigger", 32'(cc_b), 32'(0));

      // B: -512 saturates to 511
      ram_b[8] = 10'(-512);
      arm_and_rise(1, r);
      push(1, r + 21, 8, 511);
      run(21);

      // B: ready glitch at 5th scan address aborts, rescan then triggers
      fill(1, 10'd5);
      ram_b[10] = 10'd300;
      arm_and_rise(1, r);
      run(5);
      check("b addr at 5th scan", 32'(addr_b), 32'(8));
      ready_b = 1'b0;
      tick();
      check("b consec after abort", 32'(cc_b), 32'(0));
      check("b enable after abort", 32'(en_b), 32'(0));
      check("b addr held after abort", 32'(addr_b), 32'(8));
      ready_b = 1'b1;
      push(1, cyc + 21, 10, 300);
      tick();
      check("b rescan from BIN_LO", 32'(addr_b), 32'(4));
      run(20);

      // B: detector_enable drop during DECIDE suppresses the trigger
      ram_b[10] = 10'd5;
      ram_b[12] = 10'd400;
      arm_and_rise(1, r);
      run(20);
      det_en_b = 1'b0;
      tick();
      check("b no-trig enable", 32'(en_b), 32'(0));
      check("b no-trig consec", 32'(cc_b), 32'(0));
      check("b kept peak_bin", 32'(pbin_b), 32'(10));
      check("b kept peak_mag", 32'(pmag_b), 32'(300));
      run(3);
      det_en_b = 1'b1;
      run(2);

      // A: reset mid-scan
      fill(0, 10'd5);
      ram_a[10] = 10'd300;
      arm_and_rise(0, r);
      run(22);
      check("a consec before reset", 32'(cc_a), 32'(1));
      arm_and_rise(0, r);
      run(5);
      check("a addr mid-scan", 32'(addr_a), 32'(8));
      #2;
      reset_a = 1'b1;
      #1;
      check("a async rst addr", 32'(addr_a), 32'(0));
      check("a async rst enable", 32'(en_a), 32'(0));
      check("a async rst trigger", 32'(trig_a), 32'(0));
      check("a async rst peak_bin", 32'(pbin_a), 32'(0));
      check("a async rst peak_mag", 32'(pmag_a), 32'(0));
      check("a async rst consec", 32'(cc_a), 32'(0));
      tick();
      tick();
      reset_a = 1'b0;
      check("a enable before first edge", 32'(en_a), 32'(0));
      tick();
      check("a enable one cycle after release", 32'(en_a), 32'(1));
      run(30);

      check("a pending expectations", 32'(q_a.size()), 32'(0));
      check("b pending expectations", 32'(q_b.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/trigger_detector.md
Name: trigger_detector

Overview:
- Consumer stage for the trigger FFT output RAM (64 bins, 10-bit signed real part).
- After each completed FFT frame, it scans a configured bin band through the RAM read port and finds the peak magnitude.
- It asserts a one-cycle trigger after CONSEC_FRAMES consecutive frames meet THRESHOLD.
- It also gates the FFT via trigger_fft_enable, including a post-trigger holdoff.

Parameters:
- BIN_LO, 4, first scanned bin (0..63).
- BIN_HI, 20, last scanned bin (BIN_LO..63).
- THRESHOLD, 200, minimum peak magnitude, unsigned 9-bit (0..511).
- CONSEC_FRAMES, 2, consecutive qualifying frames required (1..15).
- HOLDOFF_CYCLES, 1000, cycles trigger_fft_enable stays low after a trigger (1..2^20-1).
- RAM_RD_LATENCY, 1, RAM port-B address-to-data latency in cycles (1 or 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- detector_enable  in  1  arm/run detector; low forces IDLE.
- fft_output_RAM_ready  in  1  high when the FFT is not writing the output RAM.
- fft_output_RAM_data  in  10  RAM port-B read data, two's complement.
- fft_output_RAM_addr  out  6  RAM port-B read address.
- trigger_fft_enable  out  1  permits the FFT to start a frame.
- trigger  out  1  one-cycle pulse on detection.
- peak_bin  out  6  bin of the last triggering peak.
- peak_mag  out  9  magnitude of the last triggering peak.
- consec_count  out  4  current consecutive-qualifying-frame count.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high.
- Reset values:
  - All outputs 0; state IDLE.
  - Internal running max 0; holdoff counter 0.
- All outputs are registered.
- Magnitude: mag = |data|, 9-bit unsigned; -512 saturates to 511.
- Peak update is strict (mag > running max), so on ties the lower bin wins.
- Running max resets to 0 at SCAN entry.
- States:
  - IDLE: trigger_fft_enable=0. Go to ARMED when detector_enable=1.
  - ARMED: trigger_fft_enable=1. Go to WRITING on a cycle with ready=0.
  - WRITING: trigger_fft_enable=0. Go to SCAN on the first cycle with ready=1.
  - SCAN: drives addr = BIN_LO .. BIN_HI, one address per cycle. Data for address k is valid RAM_RD_LATENCY cycles after k is driven. After BIN_HI is driven, go to DRAIN.
  - DRAIN: waits RAM_RD_LATENCY cycles for the last data, then goes to DECIDE.
  - DECIDE (1 cycle), peak >= THRESHOLD:
    - consec_count increments, saturating at 15.
    - If the new count >= CONSEC_FRAMES: trigger=1 on the next cycle, peak_bin/peak_mag latched, consec_count cleared, go to HOLDOFF.
    - Otherwise go to ARMED.
  - DECIDE, peak < THRESHOLD: consec_count=0, go to ARMED.
  - HOLDOFF: trigger_fft_enable=0. Counts HOLDOFF_CYCLES cycles, then goes to ARMED.
- Latency: with N = BIN_HI-BIN_LO+1, trigger is high exactly N+RAM_RD_LATENCY+2 cycles after the first cycle ready=1 in WRITING. Defaults give 20.
- Boundaries:
  - ready falls during SCAN/DRAIN (frame overwrite): abort the frame, clear consec_count, no trigger, go to WRITING.
  - detector_enable low in any state: next cycle is IDLE.
    - trigger_fft_enable=0.
    - consec_count cleared.
    - Any pending trigger suppressed; peak_bin/peak_mag keep their last values.
  - BIN_LO = BIN_HI: single-bin scan, N=1.
  - BIN_HI=63: the address counter must not wrap during SCAN.
  - reset mid-scan: immediate return to reset values.
  - ready=0 already on entry to ARMED: go to WRITING on the first ARMED cycle.
- trigger is never high for more than one cycle.
- trigger never occurs outside the cycle after DECIDE.

Decomposition:
- Package trigger_detect_pkg:
  - state encoding: IDLE, ARMED, WRITING, SCAN, DRAIN, DECIDE, HOLDOFF.
  - bin/magnitude width constants (6, 9).
  - abs-with-saturation function.
- One sub-module, bin_peak_tracker:
  - clear, valid, bin, data in → running max magnitude and bin out.
  - Owns the abs, strict compare and tie rule.

Test Plan:
- Defaults; RAM model with bin 10 = -300, others 5; two frames (ready high→low→high twice) → trigger once, 20 cycles after the second ready rise. peak_bin=10, peak_mag=300. trigger_fft_enable=0 for 1000 cycles, then 1.
- Single frame with bin 10=+300, then a frame with all bins=100 → no trigger. consec_count goes 1 then 0.
- Bins 7 and 15 both = 250, CONSEC_FRAMES=1 → peak_bin=7, peak_mag=250. Bin 3 = 511 (outside band) is ignored. Bin 8 = -512 → peak_mag=511, peak_bin=8.
- ready dropped for 1 cycle at the 5th SCAN address → no trigger, consec_count=0, state WRITING. The next clean frame with bin 10=300 (CONSEC_FRAMES=1) → trigger.
- detector_enable deasserted during DECIDE of a qualifying frame → no trigger pulse, trigger_fft_enable=0 next cycle, consec_count=0.
- reset asserted asynchronously mid-SCAN → all outputs 0 immediately. After release with detector_enable=1, trigger_fft_enable=1 one cycle later.
